counter_4b_checker: RTL and testbench
=====================================

// Module: counter_4b_checker
// PURPOSE
//  Receive-side checker for the 4-mode 4-bit counter interface. Snoops the counter's stimulus
//  (ENABLE, MODO, D) and its registered outputs (Q, RCO, LOAD), and predicts each output one
//  clock ahead. Flags mismatches and keeps error and carry statistics. Sits beside each counter
//  slice in the 32b chain as a synthesizable on-line monitor.
// PARAMETERS
//  ERR_CNT_W  8  width of saturating mismatch counter
//  RCO_CNT_W  16 width of saturating observed-RCO counter
//  LOCK_CNT   4  consecutive clean cycles needed to leave FAULT (1..15)
// PORTS
//  clk        in  1          clock, rising edge
//  RESET      in  1          reset: synchronous, active-high; clock clk
//  ENABLE     in  1          snooped counter enable
//  MODO       in  2          snooped mode: 00 up, 01 down, 10 down-by-3, 11 load
//  D          in  4          snooped load data
//  Q          in  4          observed counter value
//  RCO        in  1          observed ripple-carry
//  LOAD       in  1          observed load flag
//  CLR_STATS  in  1          synchronous clear of ERR_STICKY/ERR_CNT/RCO_CNT
//  ERR        out 1          1-cycle pulse, mismatch seen in previous cycle
//  ERR_CODE   out 3          {q_mis, rco_mis, load_mis} of that mismatch; holds last value
//  ERR_STICKY out 1          set by any ERR, cleared by RESET/CLR_STATS
//  ERR_CNT    out ERR_CNT_W  saturating mismatch count
//  RCO_CNT    out RCO_CNT_W  saturating count of cycles with RCO=1
//  LOCKED     out 1          1 in TRACK state
//  MODE_SEEN  out 4          mode coverage bitmap (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, exp_{Q,RCO,LOAD}=0, state IDLE. RESET overrides CLR_STATS and mismatches.
//  - Predictor (registered each cycle from observed Q, not from the model, so errors never cascade):
//    ENABLE=0 -> Q=0, RCO=0, LOAD=0
//    00: Q+1 mod 16, RCO=(Q==14), LOAD=0
//    01: Q-1 mod 16, RCO=(Q==0), LOAD=0
//    10: Q-3 mod 16, RCO=(Q<=2), LOAD=0
//    11: Q=D, RCO=0, LOAD=1
//  - Compare every non-reset cycle: mis = {Q!=exp_Q, RCO!=exp_RCO, LOAD!=exp_LOAD}.
//    If |mis, then on the next edge: ERR=1, ERR_CODE=mis, ERR_STICKY=1, ERR_CNT+1 (saturating).
//    ERR latency: 1 clk after the bad output.
//  - RCO_CNT +1 (saturating) on each cycle observed RCO=1, independent of mismatch.
//  - CLR_STATS coincident with a mismatch/RCO: clear first, then count, giving ERR_CNT=1 / RCO_CNT=1
//    and ERR_STICKY=1.
//  - FSM: IDLE (RESET high) -> TRACK on first cycle RESET low.
//    TRACK -> FAULT on mismatch.
//    FAULT: clean-cycle counter resets on any mismatch; -> TRACK after LOCK_CNT consecutive
//    clean cycles. LOCKED=1 only in TRACK, registered.
//  - RESET mid-FAULT: immediate return to IDLE, clean counter cleared, no ERR issued.
// CONFIGURATION
//  COUNTER_4B_CHECKER_COVER_EN defined:
//    MODE_SEEN[m] sets when ENABLE=1 and MODO=m on a non-reset cycle.
//    Cleared by RESET/CLR_STATS.
//  Undefined: MODE_SEEN tied 4'b0000, no coverage flops synthesized.
// STRUCTURE
//  - Package counter_4b_pkg: mode localparams (COUNT_UP, COUNT_DOWN, COUNT_3_DOWN, CHARGE),
//    checker state encoding (IDLE/TRACK/FAULT), ERR_CODE bit indices.
//  - Sub-module counter_4b_predict: combinational next {Q,RCO,LOAD} from {ENABLE,MODO,D,Q}.
//    Shared with future scoreboards.
// TESTING
//  1. RESET, then ENABLE=1 MODO=00 for 16 clks with the real counter bound
//     -> ERR never 1, RCO_CNT=1 after Q 14->15, LOCKED=1 from cycle 1.
//  2. Force Q=5 where exp_Q=4 -> ERR pulse next clk, ERR_CODE=3'b100, ERR_CNT=1, LOCKED=0;
//     4 clean clks -> LOCKED=1.
//  3. MODO=10 from Q=2 -> Q=15, RCO=1 accepted. From Q=3 -> Q=0, RCO=0 accepted.
//     Injected RCO=1 at Q=3 -> ERR_CODE=3'b010.
//  4. MODO=11 D=9 -> Q=9, LOAD=1 accepted. LOAD forced 0 -> ERR_CODE=3'b001. ENABLE=0 -> expect all 0.
//  5. 300 consecutive mismatches -> ERR_CNT=255 (saturated).
//     CLR_STATS with a coincident mismatch -> ERR_CNT=1, ERR_STICKY=1.
//  6. RESET asserted in FAULT with a mismatch pending -> no ERR, all outputs 0 next clk, state IDLE.
//     With COVER_EN defined, all 4 modes exercised -> MODE_SEEN=4'b1111.

Source files
------------

// File: rtl/counter_4b_pkg.sv
// counter_4b_pkg: shared mode codes, checker state encoding and error-code bit positions
// Contents:
//   COUNT_UP/COUNT_DOWN/COUNT_3_DOWN/CHARGE  MODO encodings of the 4-mode counter
//   chk_state_t                              checker FSM states IDLE/TRACK/FAULT
//   ERR_{Q,RCO,LOAD}_BIT                     bit positions inside ERR_CODE
package counter_4b_pkg;
  localparam logic [1:0] COUNT_UP     = 2'b00;
  localparam logic [1:0] COUNT_DOWN   = 2'b01;
  localparam logic [1:0] COUNT_3_DOWN = 2'b10;
  localparam logic [1:0] CHARGE       = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} chk_state_t;
  localparam int ERR_Q_BIT    = 2;
  localparam int ERR_RCO_BIT  = 1;
  localparam int ERR_LOAD_BIT = 0;
endpackage

// File: rtl/counter_4b_predict.sv
// counter_4b_predict: combinational next {Q,RCO,LOAD} of the 4-mode 4-bit counter
// Ports:
//   enable, modo, d  counter stimulus
//   q                current counter value
//   q_n, rco_n, load_n  values the counter registers on the next edge
module counter_4b_predict
  import counter_4b_pkg::*;
(
  input  logic       enable,
  input  logic [1:0] modo,
  input  logic [3:0] d,
  input  logic [3:0] q,
  output logic [3:0] q_n,
  output logic       rco_n,
  output logic       load_n
);
  always_comb begin
    q_n    = !enable ? 4'd0 : modo == COUNT_UP ? q + 4'd1 : modo == COUNT_DOWN ? q - 4'd1 :
             modo == COUNT_3_DOWN ? q - 4'd3 : d;
    rco_n  = enable && (modo == COUNT_UP ? q == 4'd14 : modo == COUNT_DOWN ? q == 4'd0 :
             modo == COUNT_3_DOWN ? q <= 4'd2 : 1'b0);
    load_n = enable && modo == CHARGE;
  end
endmodule

// File: rtl/counter_4b_checker.sv
// counter_4b_checker: on-line monitor predicting the 4-bit counter outputs one clock ahead
// Ports:
//   clk, RESET (sync, active-high)    clock and reset
//   ENABLE, MODO, D                   snooped counter stimulus
//   Q, RCO, LOAD                      observed counter outputs
//   CLR_STATS                         clears ERR_STICKY/ERR_CNT/RCO_CNT (and MODE_SEEN)
//   ERR, ERR_CODE, ERR_STICKY         mismatch pulse, {q,rco,load} code, sticky flag
//   ERR_CNT, RCO_CNT                  saturating mismatch / observed-RCO counters
//   LOCKED                            high while tracking cleanly
//   MODE_SEEN                         mode coverage bitmap, live only with COUNTER_4B_CHECKER_COVER_EN
module counter_4b_checker
  import counter_4b_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int RCO_CNT_W = 16,
  parameter int LOCK_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [1:0]           MODO,
  input  logic [3:0]           D,
  input  logic [3:0]           Q,
  input  logic                 RCO,
  input  logic                 LOAD,
  input  logic                 CLR_STATS,
  output logic                 ERR,
  output logic [2:0]           ERR_CODE,
  output logic                 ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [RCO_CNT_W-1:0] RCO_CNT,
  output logic                 LOCKED,
  output logic [3:0]           MODE_SEEN
);
  logic [3:0] exp_q, q_n, clean_cnt;
  logic exp_rco, exp_load, rco_n, load_n;
  logic [2:0] mis;
  logic [ERR_CNT_W-1:0] err_base;
  logic [RCO_CNT_W-1:0] rco_base;
  chk_state_t state, state_n;
  // prediction is taken from the observed Q so one bad value yields one mismatch, not a cascade
  counter_4b_predict u_predict (
    .enable(ENABLE), .modo(MODO), .d(D), .q(Q), .q_n(q_n), .rco_n(rco_n), .load_n(load_n)
  );
  // a clear coincident with an event wipes the old count first, so the event still counts
  always_comb begin
    mis               = '0;
    mis[ERR_Q_BIT]    = Q != exp_q;
    mis[ERR_RCO_BIT]  = RCO != exp_rco;
    mis[ERR_LOAD_BIT] = LOAD != exp_load;
    err_base          = CLR_STATS ? '0 : ERR_CNT;
    rco_base          = CLR_STATS ? '0 : RCO_CNT;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      exp_q      <= '0;
      exp_rco    <= 1'b0;
      exp_load   <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= '0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= '0;
      RCO_CNT    <= '0;
    end else begin
      exp_q      <= q_n;
      exp_rco    <= rco_n;
      exp_load   <= load_n;
      ERR        <= |mis;
      ERR_CODE   <= |mis ? mis : ERR_CODE;
      ERR_STICKY <= (ERR_STICKY && !CLR_STATS) || |mis;
      ERR_CNT    <= err_base + ERR_CNT_W'(|mis && err_base != '1);
      RCO_CNT    <= rco_base + RCO_CNT_W'(RCO && rco_base != '1);
    end
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      clean_cnt <= '0;
    end else begin
      state     <= state_n;
      clean_cnt <= state == FAULT && !(|mis) ? clean_cnt + 4'd1 : 4'd0;
    end
  end
  always_comb
    state_n = state == IDLE ? TRACK : |mis ? FAULT :
              state == TRACK || clean_cnt == 4'(LOCK_CNT - 1) ? TRACK : FAULT;
  always_comb LOCKED = state == TRACK;
`ifdef COUNTER_4B_CHECKER_COVER_EN
  always_ff @(posedge clk)
    if (RESET) MODE_SEEN <= '0;
    else MODE_SEEN <= (CLR_STATS ? 4'b0 : MODE_SEEN) | (ENABLE ? 4'b1 << MODO : 4'b0);
`else
  assign MODE_SEEN = 4'b0000;
`endif
endmodule

// File: tb/tb_counter_4b_checker.sv
// tb_counter_4b_checker: randomized and directed bench for counter_4b_checker with a reference model
module tb_counter_4b_checker;
  logic clk = 0, RESET = 1, ENABLE = 0, RCO = 0, LOAD = 0, CLR_STATS = 0;
  logic [1:0] MODO = 0;
  logic [3:0] D = 0, Q = 0;
  logic ERR, ERR_STICKY, LOCKED;
  logic [2:0] ERR_CODE;
  logic [7:0] ERR_CNT;
  logic [15:0] RCO_CNT;
  logic [3:0] MODE_SEEN;
  logic [33:0] dut_vec;
  int checks = 0, failures = 0;
  logic [3:0] m_eq, m_seen;
  logic m_erco, m_eload, m_err, m_sticky;
  logic [2:0] m_code;
  int m_ecnt, m_rcnt, m_run;
  bit m_active, m_ever;

  counter_4b_checker dut (
    .clk(clk), .RESET(RESET), .ENABLE(ENABLE), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO), .LOAD(LOAD),
    .CLR_STATS(CLR_STATS), .ERR(ERR), .ERR_CODE(ERR_CODE), .ERR_STICKY(ERR_STICKY),
    .ERR_CNT(ERR_CNT), .RCO_CNT(RCO_CNT), .LOCKED(LOCKED), .MODE_SEEN(MODE_SEEN)
  );

  always #5 clk = ~clk;
  assign dut_vec = {ERR, ERR_CODE, ERR_STICKY, ERR_CNT, RCO_CNT, LOCKED, MODE_SEEN};

  // counter behaviour straight from the mode table: {Q, RCO, LOAD} after the next edge
  function automatic logic [5:0] spec_next(logic en, logic [1:0] md, logic [3:0] dd, logic [3:0] qq);
    int v = int'(qq);
    if (!en) return 6'd0;
    case (md)
      2'd0: return {4'((v + 1) % 16), v == 14, 1'b0};
      2'd1: return {4'((v + 15) % 16), v == 0, 1'b0};
      2'd2: return {4'((v + 13) % 16), v <= 2, 1'b0};
      default: return {dd, 1'b0, 1'b1};
    endcase
  endfunction

  // locked once running, unless the latest mismatch is followed by fewer than 4 clean cycles
  function automatic logic m_locked();
    return m_active && (!m_ever || m_run >= 4);
  endfunction

  function automatic logic [33:0] model_vec();
    return {m_err, m_code, m_sticky, 8'(m_ecnt), 16'(m_rcnt), m_locked(), m_seen};
  endfunction

  task automatic model_update();
    logic [2:0] mis;
    if (RESET) begin
      {m_err, m_code, m_sticky, m_seen, m_eq, m_erco, m_eload} = '0;
      m_ecnt = 0; m_rcnt = 0; m_run = 0; m_active = 0; m_ever = 0;
    end else begin
      mis = {Q !== m_eq, RCO !== m_erco, LOAD !== m_eload};
      m_err = mis != 0;
      if (mis != 0) m_code = mis;
      m_sticky = (CLR_STATS ? 1'b0 : m_sticky) | (mis != 0);
      m_ecnt = (CLR_STATS ? 0 : m_ecnt) + int'(mis != 0);
      if (m_ecnt > 255) m_ecnt = 255;
      m_rcnt = (CLR_STATS ? 0 : m_rcnt) + int'(RCO);
      if (m_rcnt > 65535) m_rcnt = 65535;
      if (m_active && mis != 0) begin m_run = 0; m_ever = 1; end
      else if (m_run < 1000) m_run++;
      m_active = 1;
`ifdef COUNTER_4B_CHECKER_COVER_EN
      if (CLR_STATS) m_seen = 0;
      if (ENABLE) m_seen[MODO] = 1'b1;
`endif
      {m_eq, m_erco, m_eload} = spec_next(ENABLE, MODO, D, Q);
    end
  endtask

  // apply stimulus for one edge, update the model, then let the bound counter advance
  task automatic tick(input logic en, input logic [1:0] md, input logic [3:0] dd, input logic clr, input logic rst);
    ENABLE = en; MODO = md; D = dd; CLR_STATS = clr; RESET = rst;
    @(posedge clk);
    #1;
    model_update();
    {Q, RCO, LOAD} = rst ? 6'd0 : spec_next(ENABLE, MODO, D, Q);
  endtask

  task automatic test_reset();
    repeat (3) tick(0, 0, 0, 0, 1);
    if (dut_vec !== 34'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
    checks++;
  endtask

  task automatic test_up_count();
    for (int i = 0; i < 16; i++) begin
      tick(1, 2'b00, 4'($urandom), 0, 0);
      if (dut_vec !== model_vec()) begin failures++; $display("FAIL up_count cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
      checks++;
      if (ERR !== 1'b0 || LOCKED !== 1'b1) begin failures++; $display("FAIL up_clean cyc=%0d err=%b locked=%b exp err=0 locked=1", i, ERR, LOCKED); end
      checks++;
    end
    if (RCO_CNT !== 16'd1) begin failures++; $display("FAIL up_rco_cnt got=%0d exp=1", RCO_CNT); end
    checks++;
  endtask

  task automatic test_q_mismatch();
    repeat (4) tick(1, 2'b00, 0, 0, 0);
    Q = 4'd5;
    for (int i = 0; i < 5; i++) begin
      tick(1, 2'b00, 0, 0, 0);
      if (dut_vec !== model_vec()) begin failures++; $display("FAIL q_mis cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
      checks++;
      if (i == 0 && {ERR, ERR_CODE, ERR_CNT, LOCKED} !== {1'b1, 3'b100, 8'd1, 1'b0}) begin
        failures++; $display("FAIL q_mis_pulse got=%b/%b/%0d/%b exp=1/100/1/0", ERR, ERR_CODE, ERR_CNT, LOCKED);
      end
      if (i == 0) checks++;
      if (i == 3 && LOCKED !== 1'b0) begin failures++; $display("FAIL q_relock_early got=%b exp=0", LOCKED); end
      if (i == 4 && LOCKED !== 1'b1) begin failures++; $display("FAIL q_relock got=%b exp=1", LOCKED); end
      if (i >= 3) checks++;
    end
  endtask

  task automatic test_down3();
    tick(1, 2'b11, 4'd2, 0, 0);
    tick(1, 2'b10, 0, 0, 0);
    if (Q !== 4'd15 || RCO !== 1'b1) begin failures++; $display("FAIL down3_model got=%0d/%b exp=15/1", Q, RCO); end
    checks++;
    tick(1, 2'b11, 4'd3, 0, 0);
    if (ERR !== 1'b0) begin failures++; $display("FAIL down3_wrap got=%b exp=0", ERR); end
    checks++;
    tick(1, 2'b10, 0, 0, 0);
    tick(1, 2'b11, 4'd3, 0, 0);
    if (ERR !== 1'b0) begin failures++; $display("FAIL down3_zero got=%b exp=0", ERR); end
    checks++;
    tick(1, 2'b10, 0, 0, 0);
    RCO = 1'b1;
    tick(1, 2'b00, 0, 0, 0);
    if (ERR !== 1'b1 || ERR_CODE !== 3'b010 || dut_vec !== model_vec()) begin
      failures++; $display("FAIL down3_rco_inj got=%b/%b exp=1/010 vec=%h model=%h", ERR, ERR_CODE, dut_vec, model_vec());
    end
    checks++;
  endtask

  task automatic test_load();
    tick(1, 2'b11, 4'd9, 0, 0);
    tick(1, 2'b11, 4'd9, 0, 0);
    if (ERR !== 1'b0) begin failures++; $display("FAIL load_ok got=%b exp=0", ERR); end
    checks++;
    LOAD = 1'b0;
    tick(0, 2'b01, 0, 0, 0);
    if (ERR !== 1'b1 || ERR_CODE !== 3'b001) begin failures++; $display("FAIL load_inj got=%b/%b exp=1/001", ERR, ERR_CODE); end
    checks++;
    tick(0, 2'b10, 0, 0, 0);
    if (ERR !== 1'b0 || dut_vec !== model_vec()) begin failures++; $display("FAIL disable got=%h exp=%h", dut_vec, model_vec()); end
    checks++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      tick(1, 2'($urandom), 4'($urandom), 0, 0);
      Q = Q ^ 4'd1;
    end
    tick(1, 2'b00, 0, 0, 0);
    Q = Q ^ 4'd1;
    if (ERR_CNT !== 8'd255 || dut_vec !== model_vec()) begin failures++; $display("FAIL err_sat got=%0d exp=255", ERR_CNT); end
    checks++;
    tick(1, 2'b00, 0, 1, 0);
    if (ERR_CNT !== 8'd1 || ERR_STICKY !== 1'b1) begin failures++; $display("FAIL clr_coincident got=%0d/%b exp=1/1", ERR_CNT, ERR_STICKY); end
    checks++;
  endtask

  task automatic test_reset_in_fault();
    Q = Q ^ 4'd2;
    tick(1, 2'b00, 0, 0, 0);
    if (LOCKED !== 1'b0 || ERR !== 1'b1) begin failures++; $display("FAIL enter_fault got=%b/%b exp=0/1", LOCKED, ERR); end
    checks++;
    Q = Q ^ 4'd2;
    tick(1, 2'b00, 0, 1, 1);
    if (dut_vec !== 34'h0) begin failures++; $display("FAIL reset_in_fault got=%h exp=0", dut_vec); end
    checks++;
    tick(1, 2'b00, 0, 0, 0);
    if (LOCKED !== 1'b1 || ERR !== 1'b0) begin failures++; $display("FAIL after_reset got=%b/%b exp=1/0", LOCKED, ERR); end
    checks++;
  endtask

  task automatic test_cover();
    for (int m = 0; m < 4; m++) tick(1, 2'(m), 4'($urandom), 0, 0);
`ifdef COUNTER_4B_CHECKER_COVER_EN
    if (MODE_SEEN !== 4'b1111) begin failures++; $display("FAIL mode_seen got=%b exp=1111", MODE_SEEN); end
`else
    if (MODE_SEEN !== 4'b0000) begin failures++; $display("FAIL mode_seen got=%b exp=0000", MODE_SEEN); end
`endif
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 7) != 0, 2'($urandom), 4'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
      if (dut_vec !== model_vec()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
      checks++;
      if ($urandom_range(0, 5) == 0) {Q, RCO, LOAD} = {Q, RCO, LOAD} ^ 6'($urandom_range(1, 63));
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_q_mismatch();
    test_down3();
    test_load();
    test_saturate();
    test_reset_in_fault();
    test_cover();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
